// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch: instruction fetch stage with a one-entry instruction buffer,
// req/ack memory port, timeout and misalignment detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] NOP     = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        stall
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_tag_q, buf_tag_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          buf_vld_q, buf_vld_d;
  logic          hit;
  logic          fill;

  assign hit = buf_vld_q && (PC == buf_tag_q) && !flush;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      instr_q    <= 32'h0;
      cnt_q      <= '0;
      buf_tag_q  <= 32'h0;
      buf_data_q <= 32'h0;
      buf_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
      buf_vld_q  <= buf_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    buf_vld_d  = buf_vld_q;
    fill       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          if (PC[1:0] != 2'b00) begin
            state_d = S_ERR;
            instr_d = NOP;
          end else if (hit) begin
            state_d = S_DONE;
            instr_d = buf_data_q;
          end else begin
            state_d    = S_REQ;
            mem_addr_d = PC;
            mem_req_d  = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      S_REQ: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          fill       = 1'b1;
          instr_d    = mem_rdata;
          buf_data_d = mem_rdata;
          buf_tag_d  = mem_addr_q;
          buf_vld_d  = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          instr_d   = NOP;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush && !fill) buf_vld_d = 1'b0;
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign Instr       = instr_q;
  assign stall       = (state_q == S_REQ);
  assign instr_valid = (state_q == S_DONE) || (state_q == S_ERR);
  assign fetch_err   = (state_q == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch: scoreboard bench for instr_fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] C_NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC = 32'h0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        fetch_err;
  logic        stall;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  instr_fetch #(.TIMEOUT(15), .NOP(C_NOP)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .PC          (PC),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .stall       (stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every instr_valid pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (instr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'h0, instr_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", Instr, e.instr);
        chk("fetch_err", {31'h0, fetch_err}, {31'h0, e.err});
        chk("stall_in_result", {31'h0, stall}, 32'h0);
      end
    end
  end

  task automatic issue(input logic [31:0] pc);
    @(posedge CLK); #1;
    PC       = pc;
    fetch_en = 1'b1;
    @(posedge CLK); #1;
    fetch_en = 1'b0;
    PC       = $urandom;
  endtask

  // Plays memory: acks in the k-th request cycle (k=0 never), returns the
  // number of cycles mem_req was observed high.
  task automatic serve(input int k, input logic [31:0] data, input bit fl, output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (!mem_req) break;
      n++;
      chk("stall_tracks_req", {31'h0, stall}, 32'h1);
      if (n == k) begin
        mem_ack   = 1'b1;
        mem_rdata = data;
        flush     = fl;
      end
      @(posedge CLK); #1;
      mem_ack   = 1'b0;
      flush     = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input int k,
                       input logic [31:0] data, input bit fl,
                       input int exp_n, input exp_t e);
    int n;
    sb.push_back(e);
    issue(pc);
    serve(k, data, fl, n);
    chk({tag, "_req_cycles"}, n, exp_n);
    @(posedge CLK); #1;
    chk({tag, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  localparam logic [31:0] PC_A = 32'h0040_0000;
  localparam logic [31:0] PC_B = 32'h0040_0010;
  localparam logic [31:0] PC_C = 32'h0040_0020;
  localparam logic [31:0] PC_D = 32'h0040_0030;

  initial begin
    int n;

    // Reset with random inputs: outputs stay 0.
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      PC = $urandom; fetch_en = 1'($urandom); flush = 1'($urandom);
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      @(negedge CLK);
      chk("rst_ctrl", {28'h0, mem_req, instr_valid, fetch_err, stall}, 32'h0);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
    end
    PC = 32'h0; fetch_en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("idle_ctrl", {28'h0, mem_req, instr_valid, fetch_err, stall}, 32'h0);
    end

    // Miss then hit.
    fetch("missA", PC_A, 3, 32'h2008_000A, 1'b0, 3, '{instr: 32'h2008_000A, err: 1'b0});
    chk("addr_latched", mem_addr, PC_A);
    fetch("hitA", PC_A, 1, 32'hDEAD_BEEF, 1'b0, 0, '{instr: 32'h2008_000A, err: 1'b0});

    // Flush invalidates; flush together with an ack keeps the fill.
    @(posedge CLK); #1; flush = 1'b1;
    @(posedge CLK); #1; flush = 1'b0;
    fetch("flushA", PC_A, 2, 32'h1111_2222, 1'b0, 2, '{instr: 32'h1111_2222, err: 1'b0});
    fetch("missB_fl", PC_B, 4, 32'h3333_4444, 1'b1, 4, '{instr: 32'h3333_4444, err: 1'b0});
    fetch("hitB", PC_B, 1, 32'h0BAD_0BAD, 1'b0, 0, '{instr: 32'h3333_4444, err: 1'b0});

    // Timeout, then an ack exactly in the last allowed cycle.
    fetch("timeout", PC_C, 0, 32'h0, 1'b0, 15, '{instr: C_NOP, err: 1'b1});
    fetch("hitB_after_to", PC_B, 1, 32'h0, 1'b0, 0, '{instr: 32'h3333_4444, err: 1'b0});
    fetch("ack15", PC_D, 15, 32'h5555_6666, 1'b0, 15, '{instr: 32'h5555_6666, err: 1'b0});

    // Misaligned fetch, then buffer still hits.
    fetch("misalign", 32'h0040_0002, 1, 32'h0, 1'b0, 0, '{instr: C_NOP, err: 1'b1});
    fetch("hitD", PC_D, 1, 32'h0, 1'b0, 0, '{instr: 32'h5555_6666, err: 1'b0});

    // Reset two cycles into a miss, then a late ack.
    issue(PC_A);
    @(negedge CLK); chk("mr_req1", {31'h0, mem_req}, 32'h1);
    @(negedge CLK); chk("mr_req2", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mr_async", {28'h0, mem_req, instr_valid, fetch_err, stall}, 32'h0);
    chk("mr_addr", mem_addr, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK); reset = 1'b1;
    @(posedge CLK); #1; mem_ack = 1'b1; mem_rdata = 32'h7777_8888;
    @(posedge CLK); #1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("late_ack_ctrl", {28'h0, mem_req, instr_valid, fetch_err, stall}, 32'h0);
    end
    // Buffer was cleared by reset: the previously buffered PC must miss.
    fetch("post_rst", PC_D, 2, 32'h9999_AAAA, 1'b0, 2, '{instr: 32'h9999_AAAA, err: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle CPU: it turns the current program counter into the 32-bit instruction word consumed by the PC/immediate unit and the decoder. It drives a request/acknowledge port to a variable-latency instruction memory and keeps a one-entry instruction buffer so that re-fetching the same PC (for example a stalled or looping PC) costs no memory access. It asserts `stall` while a fetch is outstanding so the PC register can be frozen, and it reports misaligned fetches and memory timeouts.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles `mem_req` may stay high without `mem_ack`; must be at least 1.
- `NOP`, default 32'h00000000: instruction word presented on a fetch error.
- `CLK` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PC` in 32: fetch address; sampled only in IDLE.
- `fetch_en` in 1: start a fetch of `PC`; sampled only in IDLE.
- `flush` in 1: invalidates the instruction buffer; takes effect in any state.
- `mem_ack` in 1: memory has `mem_rdata` valid this cycle; honoured only in REQ.
- `mem_rdata` in 32: memory read data.
- `mem_req` out 1: read request, held high until ack or timeout.
- `mem_addr` out 32: latched fetch address.
- `Instr` out 32: fetched instruction word, held between fetches.
- `instr_valid` out 1: one-cycle pulse meaning `Instr` is new.
- `fetch_err` out 1: one-cycle pulse on a misaligned fetch or a timeout.
- `stall` out 1: high while state is REQ.

## Operation
- States:
  - IDLE.
  - REQ: memory access outstanding.
  - DONE: valid instruction presented.
  - ERR: error presented.
- Buffer: `buf_tag[31:0]`, `buf_data[31:0]`, `buf_vld`. Hit means `buf_vld & (PC == buf_tag) & ~flush`.
- In IDLE with `fetch_en=1`:
  - If `PC[1:0] != 0`, go to ERR. No memory access is made.
  - Else on a hit, go to DONE with `Instr <= buf_data`. No memory access is made.
  - Else on a miss, go to REQ with `mem_addr <= PC`, `mem_req <= 1`, and the counter cleared to 0.
- REQ:
  - On `mem_ack=1`: `Instr`, `buf_data` <= `mem_rdata`; `buf_tag` <= `mem_addr`; `buf_vld` <= 1; `mem_req` <= 0; go to DONE.
  - Otherwise, if the counter equals `TIMEOUT-1`: `mem_req` <= 0; go to ERR.
  - Otherwise the counter increments.
  - Ack and timeout in the same cycle: the ack wins.
- DONE: `instr_valid=1`; go unconditionally to IDLE. `fetch_en` is ignored in DONE.
- ERR: `instr_valid=1`, `fetch_err=1`, `Instr <= NOP` (registered on entry); go to IDLE. The buffer is left unchanged.
- `flush=1` clears `buf_vld` at the edge.
  - `flush` in the same REQ cycle as an ack: the fill wins, so `buf_vld` ends at 1 holding the new data.
- `PC` changes during REQ/DONE/ERR are ignored because the address is latched.
- `mem_ack` outside REQ is ignored, including a late ack after a timeout or reset.
- Counter width: `$clog2(TIMEOUT)+1` bits. It never wraps, because REQ exits at `TIMEOUT-1`.

## Timing
- Reset (asynchronous, any state, including mid-REQ): state IDLE, all outputs 0. `mem_addr`, `Instr`, counter, `buf_tag` and `buf_data` are 0; `buf_vld` is 0. An outstanding request is abandoned.
- Output sourcing:
  - `stall` is combinational from state (`state==REQ`).
  - `instr_valid` and `fetch_err` decode DONE/ERR.
  - All other outputs are registered.
- Hit latency: `fetch_en` at edge t, then `instr_valid` high during cycle t+1. Two cycles from issue to reissue.
- Miss latency: `mem_req` goes high after edge t. With ack sampled at edge t+k (k≥1), `instr_valid` is high during cycle t+k+1.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT` cycles, then `fetch_err` and `instr_valid` pulse high for 1 cycle.
- Misaligned: `fetch_err` is high during cycle t+1, and `mem_req` never rises.

## Test plan
- Reset: hold `reset=0` with random inputs. All outputs must stay 0. Release `reset` and assert nothing: the block stays in IDLE.
- Miss then hit:
  - `PC=0x00400000`, ack after 3 cycles with `0x2008000A`. Require `mem_req` high for 3 cycles, `Instr=0x2008000A`, and a 1-cycle `instr_valid`.
  - Refetch the same PC. Require `instr_valid` on the next cycle with no `mem_req`.
- Flush: after the fill above, pulse `flush`, then refetch `0x00400000`. Must miss and raise `mem_req`. Also assert `flush` together with an ack: a following refetch must hit.
- Timeout: `TIMEOUT=15`, never ack. Require `mem_req` high for exactly 15 cycles, then `fetch_err=1` and `Instr=0`.
  - An ack asserted in cycle 15 must complete normally with no error.
- Misaligned: `PC=0x00400002` must give `fetch_err` with no `mem_req`. A buffer hit on a valid PC afterwards must still work.
- Reset mid-REQ:
  - Assert `reset` two cycles into a miss. Require `mem_req=0` immediately (asynchronously).
  - A late `mem_ack` after release must be ignored: no `instr_valid`, and `buf_vld` stays 0.
